// File: rtl/regfile_wb_arbiter.sv
// Write-side arbiter for the 32x32 register file: ALU writeback wins, mult/div results wait in a small FIFO.
// Latency: one cycle from selection to ctrl_writeEnable; a buffered mult/div result is written no earlier than one cycle after acceptance.
// Backpressure: ALU is never stalled; md_result_ready drops when the buffer is full. Optional forwarding ports: WB_FORWARD_EN.
module regfile_wb_arbiter #(
    parameter int MD_BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_reg,
    input  logic [31:0] alu_wb_data,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_reg,
    input  logic        md_result_valid,
    output logic        md_result_ready,
    input  logic [4:0]  md_result_reg,
    input  logic [31:0] md_result_data,
    input  logic [4:0]  rd_reg_a,
    input  logic [4:0]  rd_reg_b,
    output logic        hazard_stall,
    output logic        wb_waw_err,
`ifdef WB_FORWARD_EN
    output logic        fwd_a_valid,
    output logic [31:0] fwd_a_data,
    output logic        fwd_b_valid,
    output logic [31:0] fwd_b_data,
`endif
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg
);

    localparam int PTR_W = (MD_BUF_DEPTH > 1) ? $clog2(MD_BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(MD_BUF_DEPTH + 1);

    logic [4:0]       r_buf_reg  [MD_BUF_DEPTH];
    logic [31:0]      r_buf_data [MD_BUF_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_pending;
    logic             r_waw_err;
    logic             r_we;
    logic [4:0]       r_wreg;
    logic [31:0]      r_wdata;

    logic             w_alu_go;
    logic             w_pop;
    logic             w_push;
    logic [4:0]       w_head_reg;
    logic [31:0]      w_head_data;
    logic [31:0]      w_set;
    logic [31:0]      w_clr;
    logic [31:0]      w_pending_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MD_BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Writes to r0 are dropped on both paths; a result to r0 still handshakes but is never buffered.
    assign w_alu_go        = alu_wb_valid && (alu_wb_reg != 5'd0);
    assign w_pop           = !w_alu_go && (r_count != '0);
    assign md_result_ready = (r_count < CNT_W'(MD_BUF_DEPTH));
    assign w_push          = md_result_valid && md_result_ready && (md_result_reg != 5'd0);
    assign w_head_reg      = r_buf_reg[r_rd_ptr];
    assign w_head_data     = r_buf_data[r_rd_ptr];

    // Scoreboard update: a new issue to a register outranks the clear from a same-cycle pop.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (md_issue && (md_issue_reg != 5'd0)) w_set[md_issue_reg] = 1'b1;
        if (w_pop)                              w_clr[w_head_reg]   = 1'b1;
        w_pending_nxt = (r_pending & ~w_clr) | w_set;
    end

    assign hazard_stall = ((rd_reg_a != 5'd0) && r_pending[rd_reg_a]) ||
                          ((rd_reg_b != 5'd0) && r_pending[rd_reg_b]);

    // Registered write port: ALU first, then the buffer head; reg/data hold when idle.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_we    <= 1'b0;
            r_wreg  <= 5'd0;
            r_wdata <= 32'd0;
        end else if (w_alu_go) begin
            r_we    <= 1'b1;
            r_wreg  <= alu_wb_reg;
            r_wdata <= alu_wb_data;
        end else if (w_pop) begin
            r_we    <= 1'b1;
            r_wreg  <= w_head_reg;
            r_wdata <= w_head_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    // Buffer storage is pure datapath; validity is tracked by the count and pointers.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_buf_reg[r_wr_ptr]  <= md_result_reg;
            r_buf_data[r_wr_ptr] <= md_result_data;
        end
    end

    // Buffer pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Pending-destination scoreboard and sticky WAW flag (ALU overwriting a register still owed by mult/div).
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_pending <= '0;
            r_waw_err <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_alu_go && r_pending[alu_wb_reg]) r_waw_err <= 1'b1;
        end
    end

    assign wb_waw_err       = r_waw_err;
    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wreg;
    assign data_writeReg    = r_wdata;

`ifdef WB_FORWARD_EN
    assign fwd_a_valid = r_we && (r_wreg == rd_reg_a) && (rd_reg_a != 5'd0);
    assign fwd_a_data  = r_wdata;
    assign fwd_b_valid = r_we && (r_wreg == rd_reg_b) && (rd_reg_b != 5'd0);
    assign fwd_b_data  = r_wdata;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus, write-port scoreboard checked by a negedge monitor.
// Expected writes are queued as stimulus is issued; any write with an empty queue is reported.
// Inputs driven #1 after the rising edge; outputs sampled #1 later or on the falling edge.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_reg;
    logic [31:0] alu_wb_data;
    logic        md_issue;
    logic [4:0]  md_issue_reg;
    logic        md_result_valid;
    logic        md_result_ready;
    logic [4:0]  md_result_reg;
    logic [31:0] md_result_data;
    logic [4:0]  rd_reg_a;
    logic [4:0]  rd_reg_b;
    logic        hazard_stall;
    logic        wb_waw_err;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
`ifdef WB_FORWARD_EN
    logic        fwd_a_valid;
    logic [31:0] fwd_a_data;
    logic        fwd_b_valid;
    logic [31:0] fwd_b_data;
`endif

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.MD_BUF_DEPTH(2)) dut (
        .clock(clock),
        .ctrl_reset(ctrl_reset),
        .alu_wb_valid(alu_wb_valid),
        .alu_wb_reg(alu_wb_reg),
        .alu_wb_data(alu_wb_data),
        .md_issue(md_issue),
        .md_issue_reg(md_issue_reg),
        .md_result_valid(md_result_valid),
        .md_result_ready(md_result_ready),
        .md_result_reg(md_result_reg),
        .md_result_data(md_result_data),
        .rd_reg_a(rd_reg_a),
        .rd_reg_b(rd_reg_b),
        .hazard_stall(hazard_stall),
        .wb_waw_err(wb_waw_err),
`ifdef WB_FORWARD_EN
        .fwd_a_valid(fwd_a_valid),
        .fwd_a_data(fwd_a_data),
        .fwd_b_valid(fwd_b_valid),
        .fwd_b_data(fwd_b_data),
`endif
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg)
    );

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Monitor: every write-port pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (ctrl_writeEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d data %h expected no write at %0t",
                         ctrl_writeReg, data_writeReg, $time);
            end else begin
                chk("write_port", {ctrl_writeReg, data_writeReg}, exp_q.pop_front());
            end
        end
    end

    initial begin
        ctrl_reset = 1'b1;
        alu_wb_valid = 1'b0; alu_wb_reg = 5'd0; alu_wb_data = 32'd0;
        md_issue = 1'b0; md_issue_reg = 5'd0;
        md_result_valid = 1'b0; md_result_reg = 5'd0; md_result_data = 32'd0;
        rd_reg_a = 5'd0; rd_reg_b = 5'd0;
        step(); step();
        ctrl_reset = 1'b0;
        #1;
        // Reset state
        chk("rst_we",    {36'd0, ctrl_writeEnable}, 37'd0);
        chk("rst_reg",   {32'd0, ctrl_writeReg},    37'd0);
        chk("rst_data",  {5'd0, data_writeReg},     37'd0);
        chk("rst_ready", {36'd0, md_result_ready},  37'd1);
        chk("rst_stall", {36'd0, hazard_stall},     37'd0);
        chk("rst_waw",   {36'd0, wb_waw_err},       37'd0);
        step();

        // ALU write r5 = 0xAA, one pulse
        expect_wr(5'd5, 32'h0000_00AA);
        alu_wb_valid = 1'b1; alu_wb_reg = 5'd5; alu_wb_data = 32'h0000_00AA;
        step();
        alu_wb_valid = 1'b0;
        chk("alu_we_hi", {36'd0, ctrl_writeEnable}, 37'd1);
        step();
        chk("alu_we_lo", {36'd0, ctrl_writeEnable}, 37'd0);

        // mult/div r7: stall while pending, write one cycle after acceptance, stall drops with the write
        md_issue = 1'b1; md_issue_reg = 5'd7;
        step();
        md_issue = 1'b0;
        rd_reg_a = 5'd7;
        #1;
        chk("stall_r7", {36'd0, hazard_stall}, 37'd1);
        expect_wr(5'd7, 32'h0000_1234);
        md_result_valid = 1'b1; md_result_reg = 5'd7; md_result_data = 32'h0000_1234;
        step();
        md_result_valid = 1'b0;
        chk("no_bypass_we",    {36'd0, ctrl_writeEnable}, 37'd0);
        chk("stall_r7_accept", {36'd0, hazard_stall},     37'd1);
        step();
        chk("md_we_hi",      {36'd0, ctrl_writeEnable}, 37'd1);
        chk("stall_r7_done", {36'd0, hazard_stall},     37'd0);
        rd_reg_a = 5'd0;
        step();

        // ALU burst r1..r4 while r8, r9, r10 are offered; DEPTH=2 stalls r10
        md_issue = 1'b1; md_issue_reg = 5'd8;
        step();
        md_issue = 1'b0;
        rd_reg_b = 5'd8;
        #1;
        chk("stall_b_r8", {36'd0, hazard_stall}, 37'd1);
        for (int i = 1; i <= 4; i++) expect_wr(i[4:0], 32'h100 + i);
        expect_wr(5'd8, 32'h0000_0808);
        expect_wr(5'd9, 32'h0000_0909);
        expect_wr(5'd10, 32'h0000_0A0A);
        begin
            int idx = 0;
            logic [4:0] md_regs [3];
            md_regs[0] = 5'd8; md_regs[1] = 5'd9; md_regs[2] = 5'd10;
            for (int c = 0; c < 9; c++) begin
                alu_wb_valid = (c < 4);
                alu_wb_reg   = 5'(c + 1);
                alu_wb_data  = 32'h100 + c + 1;
                md_result_valid = (idx < 3);
                md_result_reg   = md_regs[(idx < 3) ? idx : 2];
                md_result_data  = {16'd0, 3'd0, md_result_reg, 3'd0, md_result_reg};
                #1;
                if (c == 2 || c == 3 || c == 4)
                    chk("ready_full", {36'd0, md_result_ready}, 37'd0);
                if (c == 5)
                    chk("ready_after_pop", {36'd0, md_result_ready}, 37'd1);
                if (md_result_valid && md_result_ready) idx++;
                step();
            end
            alu_wb_valid = 1'b0;
            md_result_valid = 1'b0;
            chk("burst_accepted", 37'(idx), 37'd3);
        end
        step(); step();
        chk("stall_b_r8_done", {36'd0, hazard_stall}, 37'd0);
        rd_reg_b = 5'd0;

        // Writes to r0 are dropped; the md handshake still completes
        alu_wb_valid = 1'b1; alu_wb_reg = 5'd0; alu_wb_data = 32'hDEAD_BEEF;
        md_issue = 1'b1; md_issue_reg = 5'd0;
        md_result_valid = 1'b1; md_result_reg = 5'd0; md_result_data = 32'hBAD0_0000;
        #1;
        chk("r0_ready", {36'd0, md_result_ready}, 37'd1);
        step();
        alu_wb_valid = 1'b0; md_issue = 1'b0; md_result_valid = 1'b0;
        #1;
        chk("r0_stall",       {36'd0, hazard_stall},    37'd0);
        chk("r0_ready_after", {36'd0, md_result_ready}, 37'd1);
        step(); step(); step();

        // WAW: ALU overwrites pending r12; flag is sticky and the write still happens
        md_issue = 1'b1; md_issue_reg = 5'd12;
        step();
        md_issue = 1'b0;
        expect_wr(5'd12, 32'h0000_000C);
        alu_wb_valid = 1'b1; alu_wb_reg = 5'd12; alu_wb_data = 32'h0000_000C;
        #1;
        chk("waw_before", {36'd0, wb_waw_err}, 37'd0);
        step();
        alu_wb_valid = 1'b0;
        chk("waw_set", {36'd0, wb_waw_err}, 37'd1);
        step(); step(); step();
        chk("waw_sticky", {36'd0, wb_waw_err}, 37'd1);

        // Reset with two buffered results and r3 pending: nothing buffered survives
        md_issue = 1'b1; md_issue_reg = 5'd3;
        expect_wr(5'd1, 32'h0000_0001);
        alu_wb_valid = 1'b1; alu_wb_reg = 5'd1; alu_wb_data = 32'h0000_0001;
        md_result_valid = 1'b1; md_result_reg = 5'd20; md_result_data = 32'h0000_0020;
        step();
        md_issue = 1'b0;
        alu_wb_reg = 5'd2; alu_wb_data = 32'h0000_0002;
        md_result_reg = 5'd21; md_result_data = 32'h0000_0021;
        rd_reg_a = 5'd3;
        #1;
        chk("pre_rst_stall", {36'd0, hazard_stall}, 37'd1);
        step();
        alu_wb_valid = 1'b0; md_result_valid = 1'b0;
        chk("pre_rst_full", {36'd0, md_result_ready}, 37'd0);
        ctrl_reset = 1'b1;
        #1;
        chk("mid_rst_we",    {36'd0, ctrl_writeEnable}, 37'd0);
        chk("mid_rst_stall", {36'd0, hazard_stall},     37'd0);
        step();
        ctrl_reset = 1'b0;
        #1;
        chk("post_rst_ready", {36'd0, md_result_ready}, 37'd1);
        chk("post_rst_waw",   {36'd0, wb_waw_err},      37'd0);
        for (int c = 0; c < 6; c++) step();
        rd_reg_a = 5'd0;

        chk("exp_queue_drained", 37'(exp_q.size()), 37'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side front end of the 32x32 register file.
- Merges single-cycle ALU writeback with out-of-order multiply/divide results into the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg).
- Keeps a pending-destination scoreboard so decode stalls reads of registers still owed by the mult/div unit.
- Sits between the writeback stage, the multdiv unit, the decode stage and the register file.

Parameters:
- MD_BUF_DEPTH, 2, number of mult/div result entries buffered while the ALU owns the write port; must be 1..4.

Ports:
- clock  in  1  system clock, rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- alu_wb_valid  in  1  ALU result present this cycle; never stalled.
- alu_wb_reg  in  5  ALU destination register.
- alu_wb_data  in  32  ALU result.
- md_issue  in  1  mult/div op issued this cycle.
- md_issue_reg  in  5  destination of the issued mult/div op.
- md_result_valid  in  1  mult/div result offered.
- md_result_ready  out  1  result accepted when valid && ready.
- md_result_reg  in  5  mult/div result destination.
- md_result_data  in  32  mult/div result.
- rd_reg_a  in  5  decode source A.
- rd_reg_b  in  5  decode source B.
- hazard_stall  out  1  decode must hold.
- wb_waw_err  out  1  sticky: ALU wrote a pending register.
- ctrl_writeEnable  out  1  to register file.
- ctrl_writeReg  out  5  to register file.
- data_writeReg  out  32  to register file.

Behaviour:
- Reset (async): ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0; buffer empty (count=0, pointers 0); scoreboard pending[31:0]=0; wb_waw_err=0.
  - md_result_ready=1 once reset deasserts; hazard_stall=0.
  - Reset mid-operation discards buffered results and pending bits.
- Write port outputs are registered. One cycle from selection to ctrl_writeEnable high.
- Priority each cycle:
  - If alu_wb_valid && alu_wb_reg!=0, issue the ALU write.
  - Else if the buffer is non-empty, issue the head entry (FIFO order) and pop it.
  - Else ctrl_writeEnable=0. ctrl_writeReg and data_writeReg hold their last values.
- Any write with destination 0 is dropped: never issued and never buffered. A mult/div result to reg 0 is still accepted (handshake completes).
- Buffer:
  - circular FIFO of MD_BUF_DEPTH entries {reg, data}; count is 0..MD_BUF_DEPTH.
  - md_result_ready = (count < MD_BUF_DEPTH), combinational from count only (no dependence on md_result_valid).
  - Push and pop in the same cycle are allowed: count is unchanged and the pointers wrap modulo MD_BUF_DEPTH.
  - No bypass: an accepted result is issued at the earliest one cycle after acceptance, even when the buffer is empty and the ALU is idle.
- Scoreboard:
  - md_issue && md_issue_reg!=0 sets pending[md_issue_reg].
  - Popping an entry to the write port clears pending[entry.reg].
  - Same-cycle set and clear of the same bit: set wins (a new op to the same destination).
- hazard_stall = (rd_reg_a!=0 && pending[rd_reg_a]) || (rd_reg_b!=0 && pending[rd_reg_b]). Combinational from current pending state.
- wb_waw_err: set when an ALU write is issued to a register whose pending bit is 1. Sticky until reset; the write still proceeds.
- The buffer count never exceeds MD_BUF_DEPTH. The arbiter cannot push onto a full buffer because ready is low.

Optional Feature:
- WB_FORWARD_EN defined: adds outputs fwd_a_valid, fwd_a_data[31:0], fwd_b_valid, fwd_b_data[31:0].
  - fwd_x_valid=1 when ctrl_writeEnable && ctrl_writeReg==rd_reg_x && rd_reg_x!=0.
  - fwd_x_data=data_writeReg.
  - This lets decode see a value being written this cycle without a regfile write-through.
  - Additionally, hazard_stall ignores pending bits for registers being forwarded only when the forwarded write comes from the buffer pop of the prior cycle. Pending is already cleared by then, so no extra logic is required; the stall equation above stands.
- WB_FORWARD_EN undefined: forward ports are absent; no other behaviour change.

Test Plan:
- Reset, then ALU write r5=0x0000_00AA -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xAA; following cycle ctrl_writeEnable=0.
- md_issue r7; rd_reg_a=7 -> hazard_stall=1. md_result r7=0x1234 with ALU idle -> write issued 1 cycle after acceptance; pending[7] clears; hazard_stall=0 the same cycle the write appears.
- ALU valid 4 consecutive cycles (r1..r4) while md results r8, r9, r10 are offered -> r8 and r9 accepted, ready=0 for r10 (DEPTH=2). After the ALU burst, writes r8, r9, r10 appear in that order.
- ALU write r0 and md result r0 -> no ctrl_writeEnable pulse; md handshake completes; hazard_stall stays 0 for rd_reg_a=0.
- md_issue r12, then ALU write r12 -> wb_waw_err=1 and stays 1; the r12 write is still issued.
- Assert ctrl_reset with 2 entries buffered and pending[3]=1 -> immediately ctrl_writeEnable=0 and pending=0; after reset, no buffered write ever appears.
